dps_utim64_initiator: RTL and testbench

Bus initiator that drives the UTIM64 timer request/IRQ interface on behalf of a host-side command port. It serialises host reads and writes onto the single-outstanding UTIM64 request bus and services timer interrupts autonomously. Interrupt service is one fixed sequence: ACK pulse, read of the flag register, then delivery of the 8-bit flag vector to the interrupt controller through a valid/ack hold. It sits between the core's I/O fabric and the timer block.

---
 rtl/dps_utim64_pkg.sv | 37 +++
 rtl/dps_utim64_initiator_cmdbuf.sv | 35 +++
 rtl/dps_utim64_initiator.sv | 163 ++++++++++++++++
 tb/tb_dps_utim64_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dps_utim64_pkg.sv
// Shared definitions for the UTIM64 initiator: FSM encoding, RW encoding, timer address map.
// No logic; types and constants only.
// Imported by the initiator top and its command buffer.
package dps_utim64_pkg;

    // Initiator FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_IRQ_ACK   = 3'd3,
        ST_FLAG_REQ  = 3'd4,
        ST_FLAG_WAIT = 3'd5
    } state_t;

    // Request direction encoding on the UTIM64 bus
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Timer register address map (the initiator itself only needs the flag register)
    localparam logic [4:0] ADDR_CTRL_A = 5'h00;
    localparam logic [4:0] ADDR_CTRL_B = 5'h01;
    localparam logic [4:0] ADDR_FLAG   = 5'h1F;

    // One buffered host command
    typedef struct packed {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
    } cmd_t;

    // True in the states that wait for a read response and run the timeout counter
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_RD_WAIT) || (s == ST_FLAG_WAIT);
    endfunction

endpackage

// File: rtl/dps_utim64_initiator_cmdbuf.sv
// One-entry host command register with registered busy flag.
// Latency: load visible (busy high, command stable) the cycle after i_load_vld.
// Backpressure: o_busy high while full; loads are ignored until i_free empties the entry.
module dps_utim64_initiator_cmdbuf
    import dps_utim64_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load_vld,
    input  cmd_t i_load_dat,
    input  logic i_free,
    output logic o_busy,
    output cmd_t o_cmd_dat
);

    logic r_full;
    cmd_t r_cmd;

    // Fill on an accepted load, empty when the timer takes the request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_cmd  <= '0;
        end else if (i_free) begin
            r_full <= 1'b0;
        end else if (i_load_vld && !r_full) begin
            r_full <= 1'b1;
            r_cmd  <= i_load_dat;
        end
    end

    assign o_busy    = r_full;
    assign o_cmd_dat = r_cmd;

endmodule

// File: rtl/dps_utim64_initiator.sv
// Serialises host reads/writes onto the single-outstanding UTIM64 bus and services timer IRQs.
// Latency: buffered command reaches the bus 2 cycles after load; read data returns 1 cycle after response.
// Backpressure: oCMD_BUSY holds off the host; iUTIM_REQ_BUSY stalls requests; oINT_VALID held until iINT_ACK.
module dps_utim64_initiator
    import dps_utim64_pkg::*;
#(
    parameter logic [4:0] P_FLAG_ADDR  = ADDR_FLAG,
    parameter int         P_RD_TIMEOUT = 16
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iCMD_VALID,
    output logic        oCMD_BUSY,
    input  logic        iCMD_RW,
    input  logic [4:0]  iCMD_ADDR,
    input  logic [31:0] iCMD_DATA,
    output logic        oCMD_VALID,
    output logic [31:0] oCMD_DATA,
    output logic        oCMD_ERR,
    output logic        oUTIM_REQ_VALID,
    input  logic        iUTIM_REQ_BUSY,
    output logic        oUTIM_REQ_RW,
    output logic [4:0]  oUTIM_REQ_ADDR,
    output logic [31:0] oUTIM_REQ_DATA,
    input  logic        iUTIM_REQ_VALID,
    input  logic [31:0] iUTIM_REQ_DATA,
    input  logic        iUTIM_IRQ_VALID,
    output logic        oUTIM_IRQ_ACK,
    output logic        oINT_VALID,
    output logic [7:0]  oINT_FLAGS,
    input  logic        iINT_ACK
);

    localparam int TW = $clog2(P_RD_TIMEOUT + 1);

    state_t         r_state;
    state_t         w_next;
    logic [TW-1:0]  r_tmo;
    logic           r_cmd_vld;
    logic [31:0]    r_cmd_data;
    logic           r_cmd_err;
    logic           r_int_vld;
    logic [7:0]     r_int_flags;

    logic           w_busy;
    cmd_t           w_cmd;
    cmd_t           w_load_dat;
    logic           w_accept;
    logic           w_free;
    logic           w_expire;
    logic           w_resp;

    assign w_load_dat = '{rw: iCMD_RW, addr: iCMD_ADDR, data: iCMD_DATA};
    assign w_accept   = oUTIM_REQ_VALID && !iUTIM_REQ_BUSY;
    assign w_free     = (r_state == ST_REQ) && w_accept;
    // Expires on the last of P_RD_TIMEOUT cycles spent waiting; a response that same cycle wins
    assign w_expire   = (r_tmo == TW'(P_RD_TIMEOUT - 1));
    assign w_resp     = iUTIM_REQ_VALID;

    dps_utim64_initiator_cmdbuf u_cmdbuf (
        .i_clk      (iCLOCK),
        .i_rst_n    (inRESET),
        .i_load_vld (iCMD_VALID),
        .i_load_dat (w_load_dat),
        .i_free     (w_free),
        .o_busy     (w_busy),
        .o_cmd_dat  (w_cmd)
    );

    // State register
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: IRQ service wins over a buffered host command, but not while flags are undelivered
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iUTIM_IRQ_VALID && !r_int_vld) w_next = ST_IRQ_ACK;
                else if (w_busy)                   w_next = ST_REQ;
            end
            ST_REQ: begin
                if (w_accept) w_next = (w_cmd.rw == RW_WRITE) ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT:   if (w_resp || w_expire) w_next = ST_IDLE;
            ST_IRQ_ACK:   w_next = ST_FLAG_REQ;
            ST_FLAG_REQ:  if (w_accept) w_next = ST_FLAG_WAIT;
            ST_FLAG_WAIT: if (w_resp || w_expire) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Bus-facing outputs decoded from state; request fields stay stable for the whole state
    always_comb begin
        oUTIM_REQ_VALID = 1'b0;
        oUTIM_REQ_RW    = RW_READ;
        oUTIM_REQ_ADDR  = '0;
        oUTIM_REQ_DATA  = '0;
        oUTIM_IRQ_ACK   = 1'b0;
        case (r_state)
            ST_REQ: begin
                oUTIM_REQ_VALID = 1'b1;
                oUTIM_REQ_RW    = w_cmd.rw;
                oUTIM_REQ_ADDR  = w_cmd.addr;
                oUTIM_REQ_DATA  = w_cmd.data;
            end
            ST_IRQ_ACK:  oUTIM_IRQ_ACK = 1'b1;
            ST_FLAG_REQ: begin
                oUTIM_REQ_VALID = 1'b1;
                oUTIM_REQ_RW    = RW_READ;
                oUTIM_REQ_ADDR  = P_FLAG_ADDR;
            end
            default: ;
        endcase
    end

    // Timeout counter: restarts on every state change, counts only while waiting for a response
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)                 r_tmo <= '0;
        else if (w_next != r_state)   r_tmo <= '0;
        else if (is_wait_state(r_state)) r_tmo <= r_tmo + TW'(1);
    end

    // Host completion strobe and interrupt-controller flag hold
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_cmd_vld   <= 1'b0;
            r_cmd_data  <= '0;
            r_cmd_err   <= 1'b0;
            r_int_vld   <= 1'b0;
            r_int_flags <= '0;
        end else begin
            r_cmd_vld <= 1'b0;
            r_cmd_err <= 1'b0;
            if (r_state == ST_RD_WAIT) begin
                if (w_resp) begin
                    r_cmd_vld  <= 1'b1;
                    r_cmd_data <= iUTIM_REQ_DATA;
                end else if (w_expire) begin
                    r_cmd_vld  <= 1'b1;
                    r_cmd_err  <= 1'b1;
                    r_cmd_data <= 32'hFFFF_FFFF;
                end
            end
            if ((r_state == ST_FLAG_WAIT) && (w_resp || w_expire)) begin
                r_int_vld   <= 1'b1;
                r_int_flags <= w_resp ? iUTIM_REQ_DATA[7:0] : 8'h00;
            end else if (r_int_vld && iINT_ACK) begin
                r_int_vld   <= 1'b0;
            end
        end
    end

    assign oCMD_BUSY  = w_busy;
    assign oCMD_VALID = r_cmd_vld;
    assign oCMD_DATA  = r_cmd_data;
    assign oCMD_ERR   = r_cmd_err;
    assign oINT_VALID = r_int_vld;
    assign oINT_FLAGS = r_int_flags;

endmodule

// File: tb/tb_dps_utim64_initiator.sv
// Directed bench for the UTIM64 initiator: host writes/reads, stalls, IRQ service, timeouts, reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A negedge monitor tallies bus activity so steps can check pulse counts and field stability.
module tb_dps_utim64_initiator;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iCMD_VALID = 1'b0;
    logic        oCMD_BUSY;
    logic        iCMD_RW = 1'b0;
    logic [4:0]  iCMD_ADDR = '0;
    logic [31:0] iCMD_DATA = '0;
    logic        oCMD_VALID;
    logic [31:0] oCMD_DATA;
    logic        oCMD_ERR;
    logic        oUTIM_REQ_VALID;
    logic        iUTIM_REQ_BUSY = 1'b0;
    logic        oUTIM_REQ_RW;
    logic [4:0]  oUTIM_REQ_ADDR;
    logic [31:0] oUTIM_REQ_DATA;
    logic        iUTIM_REQ_VALID = 1'b0;
    logic [31:0] iUTIM_REQ_DATA = '0;
    logic        iUTIM_IRQ_VALID = 1'b0;
    logic        oUTIM_IRQ_ACK;
    logic        oINT_VALID;
    logic [7:0]  oINT_FLAGS;
    logic        iINT_ACK = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 iCLOCK = ~iCLOCK;

    dps_utim64_initiator #(
        .P_FLAG_ADDR  (5'h1F),
        .P_RD_TIMEOUT (16)
    ) dut (
        .iCLOCK          (iCLOCK),
        .inRESET         (inRESET),
        .iCMD_VALID      (iCMD_VALID),
        .oCMD_BUSY       (oCMD_BUSY),
        .iCMD_RW         (iCMD_RW),
        .iCMD_ADDR       (iCMD_ADDR),
        .iCMD_DATA       (iCMD_DATA),
        .oCMD_VALID      (oCMD_VALID),
        .oCMD_DATA       (oCMD_DATA),
        .oCMD_ERR        (oCMD_ERR),
        .oUTIM_REQ_VALID (oUTIM_REQ_VALID),
        .iUTIM_REQ_BUSY  (iUTIM_REQ_BUSY),
        .oUTIM_REQ_RW    (oUTIM_REQ_RW),
        .oUTIM_REQ_ADDR  (oUTIM_REQ_ADDR),
        .oUTIM_REQ_DATA  (oUTIM_REQ_DATA),
        .iUTIM_REQ_VALID (iUTIM_REQ_VALID),
        .iUTIM_REQ_DATA  (iUTIM_REQ_DATA),
        .iUTIM_IRQ_VALID (iUTIM_IRQ_VALID),
        .oUTIM_IRQ_ACK   (oUTIM_IRQ_ACK),
        .oINT_VALID      (oINT_VALID),
        .oINT_FLAGS      (oINT_FLAGS),
        .iINT_ACK        (iINT_ACK)
    );

    // Bus monitor: request cycles, accepts, held-field violations, strobes
    int          m_req_cyc  = 0;
    int          m_acc_n    = 0;
    int          m_hold_err = 0;
    int          m_cmd_vld  = 0;
    int          m_ack      = 0;
    logic [4:0]  m_acc_addr [0:31];
    logic        m_acc_rw   [0:31];
    logic [31:0] m_acc_data [0:31];
    logic        m_prev_stall  = 1'b0;
    logic [37:0] m_prev_fields = '0;

    always @(negedge iCLOCK) begin
        if (oUTIM_REQ_VALID) begin
            m_req_cyc <= m_req_cyc + 1;
            if (m_prev_stall && ({oUTIM_REQ_RW, oUTIM_REQ_ADDR, oUTIM_REQ_DATA} != m_prev_fields))
                m_hold_err <= m_hold_err + 1;
            if (!iUTIM_REQ_BUSY && m_acc_n < 32) begin
                m_acc_addr[m_acc_n] <= oUTIM_REQ_ADDR;
                m_acc_rw[m_acc_n]   <= oUTIM_REQ_RW;
                m_acc_data[m_acc_n] <= oUTIM_REQ_DATA;
                m_acc_n             <= m_acc_n + 1;
            end
        end
        m_prev_stall  <= oUTIM_REQ_VALID && iUTIM_REQ_BUSY;
        m_prev_fields <= {oUTIM_REQ_RW, oUTIM_REQ_ADDR, oUTIM_REQ_DATA};
        if (oCMD_VALID)    m_cmd_vld <= m_cmd_vld + 1;
        if (oUTIM_IRQ_ACK) m_ack     <= m_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge iCLOCK);
        #1;
    endtask

    // Present one host command once the buffer has room
    task automatic send_cmd(input logic rw, input logic [4:0] addr, input logic [31:0] data);
        int n = 0;
        while (oCMD_BUSY && n < 50) begin
            cyc();
            n++;
        end
        chk("cmd_slot_free", 32'(oCMD_BUSY), 32'd0);
        iCMD_VALID = 1'b1;
        iCMD_RW    = rw;
        iCMD_ADDR  = addr;
        iCMD_DATA  = data;
        cyc();
        iCMD_VALID = 1'b0;
    endtask

    // Returns at the falling edge of the cycle in which a request is on the bus
    task automatic wait_req(input string tag, input logic [4:0] exp_addr, input logic exp_rw);
        int n = 0;
        @(negedge iCLOCK);
        while (!oUTIM_REQ_VALID && n < 50) begin
            @(negedge iCLOCK);
            n++;
        end
        chk({tag, "_vld"},  32'(oUTIM_REQ_VALID), 32'd1);
        chk({tag, "_addr"}, 32'(oUTIM_REQ_ADDR), 32'(exp_addr));
        chk({tag, "_rw"},   32'(oUTIM_REQ_RW), 32'(exp_rw));
    endtask

    // Drive a one-cycle response dly cycles after the accept cycle
    task automatic respond(input logic [31:0] d, input int dly);
        cyc();
        repeat (dly) cyc();
        iUTIM_REQ_VALID = 1'b1;
        iUTIM_REQ_DATA  = d;
        cyc();
        iUTIM_REQ_VALID = 1'b0;
        iUTIM_REQ_DATA  = 32'h0;
    endtask

    // Count falling edges after an accept until sig rises
    task automatic count_to_strobe(input logic want_int, output int n);
        n = 0;
        do begin
            @(negedge iCLOCK);
            n++;
        end while (!(want_int ? oINT_VALID : oCMD_VALID) && n < 40);
    endtask

    task automatic ack_int();
        cyc();
        iINT_ACK = 1'b1;
        cyc();
        iINT_ACK = 1'b0;
    endtask

    initial begin
        int s_req, s_acc, s_cmd, s_ack, s_hold, n;

        // ---- Reset state ----
        repeat (3) cyc();
        @(negedge iCLOCK);
        chk("rst_busy",     32'(oCMD_BUSY), 32'd0);
        chk("rst_req_vld",  32'(oUTIM_REQ_VALID), 32'd0);
        chk("rst_cmd_vld",  32'(oCMD_VALID), 32'd0);
        chk("rst_irq_ack",  32'(oUTIM_IRQ_ACK), 32'd0);
        chk("rst_int_vld",  32'(oINT_VALID), 32'd0);
        chk("rst_cmd_data", oCMD_DATA, 32'd0);
        cyc();
        inRESET = 1'b1;
        repeat (2) cyc();

        // ---- Host write, timer ready: one request cycle, no completion ----
        s_req = m_req_cyc; s_acc = m_acc_n; s_cmd = m_cmd_vld;
        send_cmd(1'b1, 5'h02, 32'h0000_00FF);
        repeat (6) cyc();
        @(negedge iCLOCK);
        chk("wr_req_cycles", 32'(m_req_cyc - s_req), 32'd1);
        chk("wr_accepts",    32'(m_acc_n - s_acc), 32'd1);
        chk("wr_rw",   32'(m_acc_rw[s_acc]), 32'd1);
        chk("wr_addr", 32'(m_acc_addr[s_acc]), 32'h02);
        chk("wr_data", m_acc_data[s_acc], 32'h0000_00FF);
        chk("wr_no_cmd_vld", 32'(m_cmd_vld - s_cmd), 32'd0);
        chk("wr_busy_clear", 32'(oCMD_BUSY), 32'd0);

        // ---- Host read with 3 stalled cycles, response 2 cycles after accept ----
        cyc();
        s_req = m_req_cyc; s_cmd = m_cmd_vld; s_hold = m_hold_err;
        iUTIM_REQ_BUSY = 1'b1;
        send_cmd(1'b0, 5'h00, 32'h0);
        wait_req("rd_stall", 5'h00, 1'b0);
        repeat (3) cyc();
        iUTIM_REQ_BUSY = 1'b0;
        @(negedge iCLOCK);
        respond(32'hDEAD_BEEF, 1);
        @(negedge iCLOCK);
        chk("rd_cmd_vld",  32'(oCMD_VALID), 32'd1);
        chk("rd_cmd_data", oCMD_DATA, 32'hDEAD_BEEF);
        chk("rd_cmd_err",  32'(oCMD_ERR), 32'd0);
        repeat (3) cyc();
        @(negedge iCLOCK);
        chk("rd_req_cycles", 32'(m_req_cyc - s_req), 32'd4);
        chk("rd_hold_stable", 32'(m_hold_err - s_hold), 32'd0);
        chk("rd_cmd_vld_once", 32'(m_cmd_vld - s_cmd), 32'd1);

        // ---- IRQ service, level kept high until the flags are acknowledged ----
        cyc();
        s_ack = m_ack; s_cmd = m_cmd_vld;
        iUTIM_IRQ_VALID = 1'b1;
        wait_req("irq_flag", 5'h1F, 1'b0);
        respond(32'hABCD_EF21, 0);
        repeat (6) cyc();
        @(negedge iCLOCK);
        chk("irq_int_vld",   32'(oINT_VALID), 32'd1);
        chk("irq_flags",     32'(oINT_FLAGS), 32'h21);
        chk("irq_ack_once",  32'(m_ack - s_ack), 32'd1);
        chk("irq_no_reserv", 32'(oUTIM_REQ_VALID), 32'd0);
        chk("irq_no_cmd_vld", 32'(m_cmd_vld - s_cmd), 32'd0);
        cyc();
        iINT_ACK = 1'b1;
        iUTIM_IRQ_VALID = 1'b0;
        cyc();
        iINT_ACK = 1'b0;
        @(negedge iCLOCK);
        chk("irq_int_cleared", 32'(oINT_VALID), 32'd0);

        // ---- Stray response while idle is ignored ----
        cyc();
        s_cmd = m_cmd_vld;
        iUTIM_REQ_VALID = 1'b1;
        iUTIM_REQ_DATA  = 32'h5555_5555;
        cyc();
        iUTIM_REQ_VALID = 1'b0;
        repeat (3) cyc();
        @(negedge iCLOCK);
        chk("stray_no_cmd_vld", 32'(m_cmd_vld - s_cmd), 32'd0);
        chk("stray_no_int_vld", 32'(oINT_VALID), 32'd0);

        // ---- Host read and IRQ in the same cycle: IRQ first, then the read ----
        cyc();
        iCMD_VALID = 1'b1; iCMD_RW = 1'b0; iCMD_ADDR = 5'h03; iCMD_DATA = 32'h0;
        iUTIM_IRQ_VALID = 1'b1;
        cyc();
        iCMD_VALID = 1'b0;
        iUTIM_IRQ_VALID = 1'b0;
        @(negedge iCLOCK);
        chk("both_ack_first", 32'(oUTIM_IRQ_ACK), 32'd1);
        chk("both_buffered",  32'(oCMD_BUSY), 32'd1);
        wait_req("both_flag", 5'h1F, 1'b0);
        respond(32'h0000_0005, 0);
        wait_req("both_host", 5'h03, 1'b0);
        respond(32'h1234_5678, 0);
        @(negedge iCLOCK);
        chk("both_cmd_vld",  32'(oCMD_VALID), 32'd1);
        chk("both_cmd_data", oCMD_DATA, 32'h1234_5678);
        chk("both_int_vld",  32'(oINT_VALID), 32'd1);
        chk("both_flags",    32'(oINT_FLAGS), 32'h05);
        ack_int();

        // ---- Read timeout, then a normal read ----
        s_cmd = m_cmd_vld;
        send_cmd(1'b0, 5'h04, 32'h0);
        wait_req("tmo_rd", 5'h04, 1'b0);
        count_to_strobe(1'b0, n);
        chk("tmo_latency",  32'(n), 32'd17);
        chk("tmo_cmd_err",  32'(oCMD_ERR), 32'd1);
        chk("tmo_cmd_data", oCMD_DATA, 32'hFFFF_FFFF);
        cyc();
        @(negedge iCLOCK);
        chk("tmo_cmd_vld_once", 32'(m_cmd_vld - s_cmd), 32'd1);

        // Flag read timeout delivers an all-zero vector
        cyc();
        iUTIM_IRQ_VALID = 1'b1;
        cyc();
        iUTIM_IRQ_VALID = 1'b0;
        wait_req("tmo_flag", 5'h1F, 1'b0);
        count_to_strobe(1'b1, n);
        chk("tmo_flag_latency", 32'(n), 32'd17);
        chk("tmo_flags", 32'(oINT_FLAGS), 32'h00);
        ack_int();

        send_cmd(1'b0, 5'h06, 32'h0);
        wait_req("after_tmo", 5'h06, 1'b0);
        respond(32'h0000_600D, 0);
        @(negedge iCLOCK);
        chk("after_tmo_vld",  32'(oCMD_VALID), 32'd1);
        chk("after_tmo_data", oCMD_DATA, 32'h0000_600D);
        chk("after_tmo_err",  32'(oCMD_ERR), 32'd0);

        // ---- Reset during RD_WAIT with flags pending and a command buffered ----
        cyc();
        iUTIM_IRQ_VALID = 1'b1;
        cyc();
        iUTIM_IRQ_VALID = 1'b0;
        wait_req("pre_rst_flag", 5'h1F, 1'b0);
        respond(32'h0000_0077, 0);
        send_cmd(1'b0, 5'h07, 32'h0);
        wait_req("pre_rst_rd", 5'h07, 1'b0);
        cyc();
        send_cmd(1'b1, 5'h08, 32'hCAFE_0008);
        chk("pre_rst_busy",    32'(oCMD_BUSY), 32'd1);
        chk("pre_rst_int_vld", 32'(oINT_VALID), 32'd1);
        inRESET = 1'b0;
        #1;
        chk("rst_mid_busy",    32'(oCMD_BUSY), 32'd0);
        chk("rst_mid_int_vld", 32'(oINT_VALID), 32'd0);
        chk("rst_mid_flags",   32'(oINT_FLAGS), 32'h00);
        chk("rst_mid_req_vld", 32'(oUTIM_REQ_VALID), 32'd0);
        chk("rst_mid_cmd_vld", 32'(oCMD_VALID), 32'd0);
        repeat (2) cyc();
        inRESET = 1'b1;
        s_req = m_req_cyc; s_cmd = m_cmd_vld;
        cyc();
        iUTIM_REQ_VALID = 1'b1;
        iUTIM_REQ_DATA  = 32'h0BAD_0BAD;
        cyc();
        iUTIM_REQ_VALID = 1'b0;
        repeat (5) cyc();
        @(negedge iCLOCK);
        chk("late_resp_no_cmd_vld", 32'(m_cmd_vld - s_cmd), 32'd0);
        chk("late_resp_no_req",     32'(m_req_cyc - s_req), 32'd0);
        chk("late_resp_busy",       32'(oCMD_BUSY), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
